// File: rtl/nspld_pkg.sv
// Shared types and default timing constants for the key reader.
package nspld_pkg;

  localparam int CLK_HZ          = 12_000_000;
  localparam int DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int LONG_CYCLES     = CLK_HZ;

  typedef enum logic [2:0] {
    ST_RELEASED   = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_LONG_HELD  = 3'd3,
    ST_RELEASE_DB = 3'd4
  } key_state_e;

endpackage : nspld_pkg

// File: rtl/nspld_key_chan.sv
// One key channel: 2-flop synchronizer, debounce/hold FSM and registered
// event outputs. The key line is active-low.
module nspld_key_chan #(
  parameter int DEBOUNCE_CYCLES = nspld_pkg::DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = nspld_pkg::LONG_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);
  import nspld_pkg::*;

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [1:0]        sync_q;
  key_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_q, db_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_flag_q, long_flag_d;
  logic              pressed_q, pressed_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              s;

  assign s = sync_q[1];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    db_d        = db_q;
    hold_d      = hold_q;
    long_flag_d = long_flag_q;
    pressed_d   = pressed_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    unique case (state_q)
      ST_RELEASED: begin
        if (!s) begin
          state_d = ST_PRESS_DB;
          db_d    = DB_W'(1);
        end
      end
      ST_PRESS_DB: begin
        if (s) begin
          state_d = ST_RELEASED;
        end else if (db_q == DB_LAST) begin
          state_d   = ST_HELD;
          press_d   = 1'b1;
          pressed_d = 1'b1;
          hold_d    = '0;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      ST_HELD: begin
        if (s) begin
          state_d = ST_RELEASE_DB;
          db_d    = DB_W'(1);
        end else if (hold_q == HOLD_LAST) begin
          state_d     = ST_LONG_HELD;
          long_d      = 1'b1;
          long_flag_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_LONG_HELD: begin
        if (s) begin
          state_d = ST_RELEASE_DB;
          db_d    = DB_W'(1);
        end
      end
      ST_RELEASE_DB: begin
        // A low sample here is release bounce: resume the paused hold.
        if (!s) begin
          state_d = long_flag_q ? ST_LONG_HELD : ST_HELD;
        end else if (db_q == DB_LAST) begin
          state_d     = ST_RELEASED;
          release_d   = 1'b1;
          pressed_d   = 1'b0;
          long_flag_d = 1'b0;
          hold_d      = '0;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      default: state_d = ST_RELEASED;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      sync_q      <= 2'b11;
      state_q     <= ST_RELEASED;
      db_q        <= '0;
      hold_q      <= '0;
      long_flag_q <= 1'b0;
      pressed_q   <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_i};
      state_q     <= state_d;
      db_q        <= db_d;
      hold_q      <= hold_d;
      long_flag_q <= long_flag_d;
      pressed_q   <= pressed_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign pressed_o = pressed_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule : nspld_key_chan

// File: rtl/nspld_key_reader.sv
// Multi-key debounced reader: one independent nspld_key_chan per key line.
module nspld_key_reader #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = nspld_pkg::DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = nspld_pkg::LONG_CYCLES
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] PRESSED,
  output logic [N_KEYS-1:0] PRESS,
  output logic [N_KEYS-1:0] RELEASE,
  output logic [N_KEYS-1:0] LONG
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    nspld_key_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_chan (
      .clk_i     (CLK),
      .rst_ni    (nRST),
      .key_i     (KEY[i]),
      .pressed_o (PRESSED[i]),
      .press_o   (PRESS[i]),
      .release_o (RELEASE[i]),
      .long_o    (LONG[i])
    );
  end

endmodule : nspld_key_reader

// File: tb/tb_nspld_key_reader.sv
// Scoreboard bench for nspld_key_reader with short debounce/long timings.
module tb_nspld_key_reader;

  localparam int D = 4;
  localparam int L = 20;
  localparam int N = 2;

  logic         CLK  = 1'b0;
  logic         nRST = 1'b0;
  logic [N-1:0] KEY  = '1;
  logic [N-1:0] PRESSED, PRESS, RELEASE, LONG;

  nspld_key_reader #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .KEY     (KEY),
    .PRESSED (PRESSED),
    .PRESS   (PRESS),
    .RELEASE (RELEASE),
    .LONG    (LONG)
  );

  always #5 CLK = ~CLK;

  // cyc = number of rising edges so far; an edge's effects are seen at the
  // following falling edge with cyc equal to that edge's number.
  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    int             cyc;
    logic [N-1:0]   p;
    logic [N-1:0]   r;
    logic [N-1:0]   l;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input logic [N-1:0] p,
                           input logic [N-1:0] r, input logic [N-1:0] l);
    ev_t e;
    e.cyc = c; e.p = p; e.r = r; e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: every pulse cycle must match the next scheduled event.
  always @(negedge CLK) begin
    ev_t e;
    if ((PRESS | RELEASE | LONG) != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", int'({PRESS, RELEASE, LONG}), 0);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_bits", int'({PRESS, RELEASE, LONG}), int'({e.p, e.r, e.l}));
      end
    end
  end

  initial begin
    int t0, t1, p;

    // Reset
    nRST = 1'b0;
    KEY  = 2'b11;
    tick(2);
    check("rst_pressed", int'(PRESSED), 0);
    check("rst_press",   int'(PRESS),   0);
    check("rst_release", int'(RELEASE), 0);
    check("rst_long",    int'(LONG),    0);
    nRST = 1'b1;
    tick(3);

    // Clean press and release on key 0
    KEY = 2'b10; t0 = cyc + 1;
    expect_ev(t0 + 5, 2'b01, 2'b00, 2'b00);
    tick(5);
    check("clean_not_yet", int'(PRESSED), 0);
    tick(1);
    check("clean_pressed", int'(PRESSED), 1);
    tick(3);
    KEY = 2'b11; t1 = cyc + 1;
    expect_ev(t1 + 5, 2'b00, 2'b01, 2'b00);
    tick(5);
    check("release_db_held", int'(PRESSED), 1);
    tick(1);
    check("released", int'(PRESSED), 0);
    tick(4);

    // Bounce: three low samples are not enough
    KEY = 2'b10;
    tick(3);
    KEY = 2'b11;
    tick(10);
    check("bounce_pressed", int'(PRESSED), 0);

    // Long press held well past the long threshold
    KEY = 2'b10; t0 = cyc + 1;
    expect_ev(t0 + 5,  2'b01, 2'b00, 2'b00);
    expect_ev(t0 + 25, 2'b00, 2'b00, 2'b01);
    tick(6);
    check("long_pressed", int'(PRESSED), 1);
    tick(120);
    check("long_still_pressed", int'(PRESSED), 1);
    KEY = 2'b11; t1 = cyc + 1;
    expect_ev(t1 + 5, 2'b00, 2'b01, 2'b00);
    tick(8);
    check("long_released", int'(PRESSED), 0);

    // Release bounce pauses the hold count for three edges
    KEY = 2'b10; t0 = cyc + 1; p = t0 + 5;
    expect_ev(p, 2'b01, 2'b00, 2'b00);
    tick(9);
    KEY = 2'b11;
    tick(2);
    KEY = 2'b10;
    expect_ev(p + 23, 2'b00, 2'b00, 2'b01);
    tick(3);
    check("rel_bounce_pressed", int'(PRESSED), 1);
    tick(25);
    KEY = 2'b11; t1 = cyc + 1;
    expect_ev(t1 + 5, 2'b00, 2'b01, 2'b00);
    tick(8);
    check("rel_bounce_released", int'(PRESSED), 0);

    // Simultaneous keys
    KEY = 2'b00; t0 = cyc + 1;
    expect_ev(t0 + 5, 2'b11, 2'b00, 2'b00);
    tick(6);
    check("both_pressed", int'(PRESSED), 3);
    tick(3);
    KEY = 2'b11; t1 = cyc + 1;
    expect_ev(t1 + 5, 2'b00, 2'b11, 2'b00);
    tick(8);
    check("both_released", int'(PRESSED), 0);

    // Reset mid-hold, key kept low throughout
    KEY = 2'b10; t0 = cyc + 1;
    expect_ev(t0 + 5, 2'b01, 2'b00, 2'b00);
    tick(8);
    check("pre_reset_pressed", int'(PRESSED), 1);
    nRST = 1'b0;
    tick(1);
    check("mid_rst_pressed", int'(PRESSED), 0);
    check("mid_rst_pulses", int'({PRESS, RELEASE, LONG}), 0);
    nRST = 1'b1; t0 = cyc + 1;
    expect_ev(t0 + 5, 2'b01, 2'b00, 2'b00);
    tick(5);
    check("after_rst_not_yet", int'(PRESSED), 0);
    tick(1);
    check("after_rst_pressed", int'(PRESSED), 1);
    tick(2);
    KEY = 2'b11; t1 = cyc + 1;
    expect_ev(t1 + 5, 2'b00, 2'b01, 2'b00);
    tick(10);

    check("events_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nspld_key_reader
